// File: rtl/uart_apb_init_arbiter.sv
// Programs a 16550-style UART after reset, then round-robin shares it between two APB masters.
// Optional slave-response watchdog: define UART_ARB_TIMEOUT_EN.
module uart_apb_init_arbiter #(
    parameter int ClkFreqHz     = 50000000,
    parameter int BaudRate      = 115200,
    parameter int TimeoutCycles = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        m0_psel_i,
    input  logic        m0_penable_i,
    input  logic        m0_pwrite_i,
    input  logic [31:0] m0_paddr_i,
    input  logic [31:0] m0_pwdata_i,
    output logic [31:0] m0_prdata_o,
    output logic        m0_pready_o,
    output logic        m0_pslverr_o,
    input  logic        m1_psel_i,
    input  logic        m1_penable_i,
    input  logic        m1_pwrite_i,
    input  logic [31:0] m1_paddr_i,
    input  logic [31:0] m1_pwdata_i,
    output logic [31:0] m1_prdata_o,
    output logic        m1_pready_o,
    output logic        m1_pslverr_o,
    output logic        uart_psel_o,
    output logic        uart_penable_o,
    output logic        uart_pwrite_o,
    output logic [31:0] uart_paddr_o,
    output logic [31:0] uart_pwdata_o,
    input  logic [31:0] uart_prdata_i,
    input  logic        uart_pready_i,
    input  logic        uart_pslverr_i,
    output logic        init_done_o
);

    localparam logic [15:0] Divisor = 16'((ClkFreqHz + 8 * BaudRate) / (16 * BaudRate));

    typedef enum logic [2:0] {
        INIT_SETUP  = 3'd0,
        INIT_ACCESS = 3'd1,
        IDLE        = 3'd2,
        SETUP       = 3'd3,
        ACCESS      = 3'd4
    } state_e;

    function automatic logic [31:0] rom_addr(input logic [2:0] idx);
        logic [31:0] a;
        case (idx)
            3'd0:    a = 32'h0000_000C;
            3'd1:    a = 32'h0000_0000;
            3'd2:    a = 32'h0000_0004;
            3'd3:    a = 32'h0000_000C;
            3'd4:    a = 32'h0000_0008;
            3'd5:    a = 32'h0000_0004;
            default: a = 32'h0000_0000;
        endcase
        return a;
    endfunction

    function automatic logic [31:0] rom_data(input logic [2:0] idx);
        logic [31:0] d;
        case (idx)
            3'd0:    d = 32'h0000_0083;
            3'd1:    d = {24'h00_0000, Divisor[7:0]};
            3'd2:    d = {24'h00_0000, Divisor[15:8]};
            3'd3:    d = 32'h0000_0003;
            3'd4:    d = 32'h0000_0007;
            3'd5:    d = 32'h0000_0000;
            default: d = 32'h0000_0000;
        endcase
        return d;
    endfunction

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic        init_done_q, init_done_d;
    logic        psel_q, psel_d;
    logic        penable_q, penable_d;
    logic        pwrite_q, pwrite_d;
    logic [31:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic        done_s;
    logic [31:0] rdata_s;
    logic        err_s;
    logic        unused_s;

    // Phase requests are regenerated here, so master penable carries no information.
    assign unused_s = m0_penable_i ^ m1_penable_i;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CntW = (TimeoutCycles > 255) ? $clog2(TimeoutCycles + 1) : 8;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout_s;

    assign timeout_s = ((state_q == ACCESS) || (state_q == INIT_ACCESS)) && !uart_pready_i
                       && (cnt_q >= CntW'(TimeoutCycles - 1));
    assign done_s    = uart_pready_i || timeout_s;
    assign rdata_s   = timeout_s ? 32'hDEAD_BEEF : uart_prdata_i;
    assign err_s     = timeout_s ? 1'b1 : uart_pslverr_i;

    // Watchdog counter restarts on every state change.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q == ACCESS) || (state_q == INIT_ACCESS)) begin
            cnt_d = cnt_q + CntW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    localparam int unused_timeout_cycles = TimeoutCycles;
    assign done_s  = uart_pready_i;
    assign rdata_s = uart_prdata_i;
    assign err_s   = uart_pslverr_i;
`endif

    // State and registered UART-side outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= INIT_SETUP;
            idx_q        <= 3'd0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            init_done_q  <= 1'b0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= 32'h0000_0000;
            pwdata_q     <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            init_done_q  <= init_done_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
        end
    end

    // Next-state, init sequencing and round-robin arbitration.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        init_done_d  = init_done_q;
        case (state_q)
            INIT_SETUP: begin
                // First cycle out of reset has no setup phase on the bus yet.
                if (psel_q) begin
                    state_d = INIT_ACCESS;
                end else begin
                    state_d = INIT_SETUP;
                end
            end
            INIT_ACCESS: begin
                if (done_s && (idx_q == 3'd5)) begin
                    state_d     = IDLE;
                    idx_d       = 3'd0;
                    init_done_d = 1'b1;
                end else if (done_s) begin
                    state_d = INIT_SETUP;
                    idx_d   = idx_q + 3'd1;
                end else begin
                    state_d = INIT_ACCESS;
                end
            end
            IDLE: begin
                if (m0_psel_i && m1_psel_i) begin
                    grant_d = ~last_grant_q;
                    state_d = SETUP;
                end else if (m0_psel_i || m1_psel_i) begin
                    grant_d = m1_psel_i;
                    state_d = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (done_s) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end else begin
                    state_d = ACCESS;
                end
            end
            default: begin
                state_d = INIT_SETUP;
                idx_d   = 3'd0;
            end
        endcase
    end

    // UART bus values are computed for the upcoming state so they register in step with it.
    always_comb begin
        psel_d    = (state_d != IDLE);
        penable_d = (state_d == INIT_ACCESS) || (state_d == ACCESS);
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        if ((state_d == INIT_SETUP) || (state_d == INIT_ACCESS)) begin
            pwrite_d = 1'b1;
            paddr_d  = rom_addr(idx_d);
            pwdata_d = rom_data(idx_d);
        end else if ((state_q == IDLE) && (state_d == SETUP)) begin
            pwrite_d = grant_d ? m1_pwrite_i : m0_pwrite_i;
            paddr_d  = grant_d ? m1_paddr_i  : m0_paddr_i;
            pwdata_d = grant_d ? m1_pwdata_i : m0_pwdata_i;
        end else begin
            pwrite_d = pwrite_q;
        end
    end

    // Master responses appear combinationally in the completion cycle only.
    always_comb begin
        m0_pready_o  = 1'b0;
        m0_pslverr_o = 1'b0;
        m0_prdata_o  = 32'h0000_0000;
        m1_pready_o  = 1'b0;
        m1_pslverr_o = 1'b0;
        m1_prdata_o  = 32'h0000_0000;
        if ((state_q == ACCESS) && done_s && !grant_q) begin
            m0_pready_o  = 1'b1;
            m0_pslverr_o = err_s;
            m0_prdata_o  = rdata_s;
        end else if ((state_q == ACCESS) && done_s && grant_q) begin
            m1_pready_o  = 1'b1;
            m1_pslverr_o = err_s;
            m1_prdata_o  = rdata_s;
        end else begin
            m0_pready_o = 1'b0;
        end
    end

    assign uart_psel_o    = psel_q;
    assign uart_penable_o = penable_q;
    assign uart_pwrite_o  = pwrite_q;
    assign uart_paddr_o   = paddr_q;
    assign uart_pwdata_o  = pwdata_q;
    assign init_done_o    = init_done_q;

endmodule

// File: tb/tb_uart_apb_init_arbiter.sv
// Directed self-checking bench for uart_apb_init_arbiter (init ROM, latency, round-robin, reset, watchdog).
module tb_uart_apb_init_arbiter;

    localparam int TimeoutCycles = 255;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        m0_psel, m0_penable, m0_pwrite;
    logic [31:0] m0_paddr, m0_pwdata, m0_prdata;
    logic        m0_pready, m0_pslverr;
    logic        m1_psel, m1_penable, m1_pwrite;
    logic [31:0] m1_paddr, m1_pwdata, m1_prdata;
    logic        m1_pready, m1_pslverr;
    logic        uart_psel, uart_penable, uart_pwrite;
    logic [31:0] uart_paddr, uart_pwdata, uart_prdata;
    logic        uart_pready, uart_pslverr;
    logic        init_done;

    uart_apb_init_arbiter #(.TimeoutCycles(TimeoutCycles)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .m0_psel_i(m0_psel), .m0_penable_i(m0_penable), .m0_pwrite_i(m0_pwrite),
        .m0_paddr_i(m0_paddr), .m0_pwdata_i(m0_pwdata), .m0_prdata_o(m0_prdata),
        .m0_pready_o(m0_pready), .m0_pslverr_o(m0_pslverr),
        .m1_psel_i(m1_psel), .m1_penable_i(m1_penable), .m1_pwrite_i(m1_pwrite),
        .m1_paddr_i(m1_paddr), .m1_pwdata_i(m1_pwdata), .m1_prdata_o(m1_prdata),
        .m1_pready_o(m1_pready), .m1_pslverr_o(m1_pslverr),
        .uart_psel_o(uart_psel), .uart_penable_o(uart_penable), .uart_pwrite_o(uart_pwrite),
        .uart_paddr_o(uart_paddr), .uart_pwdata_o(uart_pwdata), .uart_prdata_i(uart_prdata),
        .uart_pready_i(uart_pready), .uart_pslverr_i(uart_pslverr),
        .init_done_o(init_done)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] log_addr [64];
    logic [31:0] log_data [64];
    logic        log_wr   [64];
    int          log_cyc  [64];
    int          log_n = 0;
    logic        early_resp = 1'b0;

    // Cycle counter.
    always @(posedge clk) cyc <= cyc + 1;

    // UART-side transfer log and pre-init response watch.
    always @(negedge clk) begin
        if (uart_psel && uart_penable && uart_pready && log_n < 64) begin
            log_addr[log_n] = uart_paddr;
            log_data[log_n] = uart_pwrite ? uart_pwdata : uart_prdata;
            log_wr[log_n]   = uart_pwrite;
            log_cyc[log_n]  = cyc;
            log_n           = log_n + 1;
        end
        if ((m0_pready || m1_pready) && !init_done && rst_ni) early_resp = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    logic [31:0] exp_addr [6];
    logic [31:0] exp_data [6];
    int          base;
    int          done_cyc;
    bit          found;
    int          g_seq  [8];
    logic [31:0] g_addr [8];
    int          n_g, c0, c1, hits, waited;

    initial begin
        exp_addr = '{32'h0C, 32'h00, 32'h04, 32'h0C, 32'h08, 32'h04};
        exp_data = '{32'h83, 32'h1B, 32'h00, 32'h03, 32'h07, 32'h00};
        rst_ni = 1'b0;
        m0_psel = 1'b0; m0_penable = 1'b0; m0_pwrite = 1'b0; m0_paddr = 32'h0; m0_pwdata = 32'h0;
        m1_psel = 1'b0; m1_penable = 1'b0; m1_pwrite = 1'b0; m1_paddr = 32'h0; m1_pwdata = 32'h0;
        uart_prdata = 32'h0; uart_pready = 1'b1; uart_pslverr = 1'b0;
        repeat (3) tick();

        check("rst_psel", {31'h0, uart_psel}, 32'h0);
        check("rst_penable", {31'h0, uart_penable}, 32'h0);
        check("rst_paddr", uart_paddr, 32'h0);
        check("rst_pwdata", uart_pwdata, 32'h0);
        check("rst_init_done", {31'h0, init_done}, 32'h0);
        check("rst_m0_pready", {31'h0, m0_pready}, 32'h0);
        check("rst_m1_pready", {31'h0, m1_pready}, 32'h0);
        check("rst_m0_prdata", m0_prdata, 32'h0);

        // Release reset with an m1 write already pending; it must wait for init.
        rst_ni = 1'b1;
        m1_psel = 1'b1; m1_penable = 1'b1; m1_pwrite = 1'b1; m1_paddr = 32'h00; m1_pwdata = 32'h41;

        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            tick();
            if (uart_psel && uart_penable && uart_paddr == 32'h00) found = 1'b1;
        end
        check("find_step2", {31'h0, found}, 32'h1);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            tick();
            if (uart_psel && uart_penable && uart_paddr == 32'h04) found = 1'b1;
        end
        check("find_step3", {31'h0, found}, 32'h1);

        rst_ni = 1'b0;
        tick();
        check("midrst_psel", {31'h0, uart_psel}, 32'h0);
        check("midrst_penable", {31'h0, uart_penable}, 32'h0);
        check("midrst_paddr", uart_paddr, 32'h0);
        check("midrst_m1_pready", {31'h0, m1_pready}, 32'h0);
        rst_ni = 1'b1;
        base = log_n;

        found = 1'b0;
        done_cyc = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (init_done) begin
                found = 1'b1;
                done_cyc = cyc;
            end
        end
        check("init_done_seen", {31'h0, found}, 32'h1);
        check("init_count", log_n - base, 32'd6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("init_addr%0d", i), log_addr[base + i], exp_addr[i]);
            check($sformatf("init_data%0d", i), log_data[base + i], exp_data[i]);
            check($sformatf("init_wr%0d", i), {31'h0, log_wr[base + i]}, 32'h1);
        end
        check("init_done_timing", done_cyc - log_cyc[base + 5], 32'd1);

        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (m1_pready) begin
                found = 1'b1;
                m1_psel = 1'b0;
            end
        end
        check("m1_served", {31'h0, found}, 32'h1);
        check("no_resp_before_init", {31'h0, early_resp}, 32'h0);
        repeat (5) tick();
        hits = 0;
        for (int i = base + 6; i < log_n; i++)
            if (log_addr[i] == 32'h00 && log_data[i] == 32'h41 && log_wr[i]) hits++;
        check("m1_write_once", hits, 32'd1);

        // m0 read: IDLE sees it at the next edge, completion two cycles later.
        m0_psel = 1'b1; m0_pwrite = 1'b0; m0_paddr = 32'h14; uart_prdata = 32'h60;
        tick();
        check("m0_rd_lat1_pready", {31'h0, m0_pready}, 32'h0);
        tick();
        check("m0_rd_lat2_pready", {31'h0, m0_pready}, 32'h1);
        check("m0_rd_prdata", m0_prdata, 32'h60);
        check("m0_rd_pslverr", {31'h0, m0_pslverr}, 32'h0);
        check("m0_rd_paddr", uart_paddr, 32'h14);
        check("m0_rd_m1_pready", {31'h0, m1_pready}, 32'h0);
        m0_psel = 1'b0;
        repeat (3) tick();

        // Contention: last grant was m0, so m1 wins the first tie.
        m0_psel = 1'b1; m0_pwrite = 1'b1; m0_paddr = 32'h10; m0_pwdata = 32'hA0;
        m1_psel = 1'b1; m1_pwrite = 1'b1; m1_paddr = 32'h18; m1_pwdata = 32'hB1;
        n_g = 0; c0 = 0; c1 = 0;
        for (int i = 0; i < 100 && n_g < 8; i++) begin
            tick();
            if (m0_pready && m1_pready) check("dual_pready", 32'h1, 32'h0);
            if (m0_pready) begin
                g_seq[n_g] = 0; g_addr[n_g] = uart_paddr; n_g++; c0++;
                if (c0 == 4) m0_psel = 1'b0;
            end else if (m1_pready) begin
                g_seq[n_g] = 1; g_addr[n_g] = uart_paddr; n_g++; c1++;
                if (c1 == 4) m1_psel = 1'b0;
            end
        end
        m0_psel = 1'b0; m1_psel = 1'b0;
        check("rr_count", n_g, 32'd8);
        for (int i = 0; i < n_g; i++) begin
            check($sformatf("rr_grant%0d", i), g_seq[i], (i % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("rr_addr%0d", i), g_addr[i], (g_seq[i] == 1) ? 32'h18 : 32'h10);
        end
        repeat (3) tick();

        // UART never ready.
        uart_pready = 1'b0;
        m0_psel = 1'b1; m0_pwrite = 1'b0; m0_paddr = 32'h14;
`ifdef UART_ARB_TIMEOUT_EN
        found = 1'b0; waited = 0;
        for (int i = 0; i < TimeoutCycles + 20 && !found; i++) begin
            tick();
            waited++;
            if (m0_pready) found = 1'b1;
        end
        check("to_completed", {31'h0, found}, 32'h1);
        check("to_pslverr", {31'h0, m0_pslverr}, 32'h1);
        check("to_prdata", m0_prdata, 32'hDEAD_BEEF);
        check("to_not_early", {31'h0, (waited >= TimeoutCycles)}, 32'h1);
        m0_psel = 1'b0;
        uart_pready = 1'b1;
        tick();
`else
        hits = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (m0_pready) hits++;
        end
        check("hang_no_pready", hits, 32'd0);
        check("hang_psel", {31'h0, uart_psel}, 32'h1);
        check("hang_penable", {31'h0, uart_penable}, 32'h1);
        uart_pready = 1'b1;
        #1;
        check("hang_release_pready", {31'h0, m0_pready}, 32'h1);
        check("hang_release_pslverr", {31'h0, m0_pslverr}, 32'h0);
        m0_psel = 1'b0;
        tick();
`endif
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
